uart_param: RTL

Parametrised full-duplex UART with an independent transmitter and receiver sharing one clock. It generalises the fixed 8N1 UART to configurable bit period, data width (5–9), parity mode and stop-bit count. The receiver adds an input synchroniser, false-start rejection, and parity/framing error reporting. The transmitter adds a ready/valid handshake.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART.
//   parity_t    - parity mode selection (none / odd / even)
//   tx_state_t  - transmitter FSM states
//   rx_state_t  - receiver FSM states
//   parity_bit  - parity bit for a data word (word zero-extended to 9 bits)
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_ODD,
        PARITY_EVEN
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Zero padding of narrow words does not change the XOR reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_t mode);
        case (mode)
            PARITY_EVEN: return ^data;
            PARITY_ODD:  return ~^data;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable bit-period down-counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - restart the period this cycle
//   half       - when loading, load a half period instead of a full one
//   tick       - high in the last cycle of each period; the counter then
//                wraps to a full period on its own
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= half ? HALF_LD : FULL_LD;
        else if (cnt == '0)
            cnt <= FULL_LD;
        else
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART (one clock for both directions).
//   Parameters: CLKS_PER_BIT (>=4), DATA_BITS (5..9), PARITY, STOP_BITS (1..2)
//   TX: tx_data/tx_data_valid in (accepted when tx_ready), tx_ready, tx_busy,
//       tx_done (one-cycle pulse at frame end), tx_serial (idle high)
//   RX: rx_serial in (asynchronous), rx_data (held), rx_data_valid pulse,
//       rx_parity_err / rx_frame_err valid alongside rx_data_valid
module uart_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter parity_t     PARITY       = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_data_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("uart_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_param: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_param: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned IW         = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state, tx_next;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic [IW-1:0]        tx_idx;
    logic                 tx_tick;
    logic                 tx_accept;
    logic                 tx_done_q;

    assign tx_accept = (tx_state == TX_IDLE) && tx_data_valid;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_accept),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_data_valid) tx_next = TX_START;
            TX_START:  if (tx_tick) tx_next = TX_DATA;
            TX_DATA:   if (tx_tick && tx_idx == LAST_BIT)
                           tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP;
            TX_STOP:   if (tx_tick && tx_idx == LAST_STOP) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // tx_idx counts data bits, then is reused to count stop bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_idx    <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (tx_accept) begin
                tx_shift <= tx_data;
                tx_par   <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
                tx_idx   <= '0;
            end else if (tx_tick) begin
                case (tx_state)
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= (tx_idx == LAST_BIT) ? '0 : tx_idx + 1'b1;
                    end
                    TX_STOP: begin
                        tx_idx <= tx_idx + 1'b1;
                        if (tx_idx == LAST_STOP) tx_done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tx_ready = (tx_state == TX_IDLE);
        tx_busy  = !tx_ready;
        tx_done  = tx_done_q;
        case (tx_state)
            TX_START:  tx_serial = 1'b0;
            TX_DATA:   tx_serial = tx_shift[0];
            TX_PARITY: tx_serial = tx_par;
            default:   tx_serial = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- RX
    logic                 rx_sync1, rx_sync2;
    rx_state_t            rx_state, rx_next;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic [IW-1:0]        rx_idx;
    logic                 rx_tick;
    logic                 rx_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= rx_serial;
            rx_sync2 <= rx_sync1;
        end
    end

    // Loading a half period on the start edge puts every later tick mid-bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rx_load),
        .half  (1'b1),
        .tick  (rx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_sync2) rx_next = RX_START;
            RX_START:     if (rx_tick) rx_next = rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_tick && rx_idx == LAST_BIT)
                              rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
            RX_STOP:      if (rx_tick) rx_next = rx_sync2 ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync2) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_load = (rx_state == RX_IDLE) && !rx_sync2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_idx        <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            if (rx_tick) begin
                case (rx_state)
                    RX_START:  rx_idx <= '0;
                    RX_DATA: begin
                        rx_shift <= {rx_sync2, rx_shift[DATA_BITS-1:1]};
                        rx_idx   <= rx_idx + 1'b1;
                    end
                    RX_PARITY: rx_par <= rx_sync2;
                    RX_STOP: begin
                        rx_data       <= rx_shift;
                        rx_data_valid <= 1'b1;
                        rx_parity_err <= HAS_PARITY &&
                            (rx_par != parity_bit(MAX_DATA_BITS'(rx_shift), PARITY));
                        rx_frame_err  <= !rx_sync2;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
